// File: rtl/fpu_pkg.sv
// Shared widths, rounding-mode encoding, flag layout and round-increment helper
// for the FPU round/pack stage.
package fpu_pkg;

    localparam int unsigned EXP_W   = 11;
    localparam int unsigned FRAC_W  = 52;
    localparam int unsigned BIAS    = 1023;
    localparam int unsigned EXP_MAX = 2047;

    localparam int unsigned SIG_W   = FRAC_W + 1;        // significand incl. hidden bit
    localparam int unsigned EXPI_W  = EXP_W + 2;         // signed exponent with range guard bits
    localparam int unsigned SIGI_W  = FRAC_W + 3;        // {hidden, fraction, guard, sticky}
    localparam int unsigned RES_W   = 1 + EXP_W + FRAC_W;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RZ  = 2'b01,
        RM_RU  = 2'b10,
        RM_RD  = 2'b11
    } rm_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } flags_t;

    // Operand state carried from the round-decision stage into the pack stage
    typedef struct packed {
        logic              sign;
        logic [EXPI_W-1:0] exp;
        logic [SIG_W-1:0]  sig;
        logic              inc;
        logic              inx;
        rm_e               rm;
    } s1_t;

    // Whether the truncated significand must be bumped by one ulp
    function automatic logic round_inc(input rm_e rm, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        logic inc;
        inc = 1'b0;
        case (rm)
            RM_RNE:  inc = g & (s | lsb);
            RM_RZ:   inc = 1'b0;
            RM_RU:   inc = ~sign & (g | s);
            RM_RD:   inc = sign & (g | s);
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/andtree.sv
// AND-reduction of an n-bit vector.
//   a    in  n  vector to test
//   y_c  out 1  1 when every bit of a is 1 (combinational)
module andtree #(
    parameter int unsigned n = 8
) (
    input  logic [n-1:0] a,
    output logic         y_c
);

    assign y_c = &a;

endmodule

// File: rtl/round_pack_pipe.sv
// Final FPU stage: rounds a normalized sign/exponent/significand, re-normalizes
// on carry-out, detects overflow/underflow and packs a binary64 result behind a
// two-stage valid/ready pipeline.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   sign_i, exp_i       sign and signed biased exponent (EXP_W+2 bits)
//   sig_i               {hidden, fraction, guard, sticky}
//   rm_i                rounding mode (rm_e encoding)
//   out_valid/out_ready result handshake
//   res_o               {sign, exp, frac}
//   flags_o             {overflow, underflow, inexact}
module round_pack_pipe
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_i,
    input  logic [EXPI_W-1:0] exp_i,
    input  logic [SIGI_W-1:0] sig_i,
    input  logic [1:0]        rm_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RES_W-1:0]  res_o,
    output logic [2:0]        flags_o
);

    logic s1_v;
    logic s2_v;
    logic s2_adv;
    s1_t  s1_d;
    s1_t  s1_q;

    logic [SIG_W:0]    sum;
    logic              carry;
    logic [FRAC_W-1:0] frac_adj;
    logic [EXPI_W-1:0] exp_adj;
    logic              exp_all_ones;
    logic              ovf;
    logic              unf;
    logic              ovf_inf;
    logic [RES_W-1:0]  res_d;
    flags_t            flags_d;

    // Handshake: S2 frees when empty or drained; S1 accepts when empty or S2 frees
    assign s2_adv    = ~s2_v | out_ready;
    assign in_ready  = ~s1_v | s2_adv;
    assign out_valid = s2_v;

    // S1: round decision
    always_comb begin
        s1_d.sign = sign_i;
        s1_d.exp  = exp_i;
        s1_d.sig  = sig_i[SIGI_W-1:2];
        s1_d.inx  = sig_i[1] | sig_i[0];
        s1_d.rm   = rm_e'(rm_i);
        s1_d.inc  = round_inc(rm_e'(rm_i), sign_i, sig_i[2], sig_i[1], sig_i[0]);
    end

    // S2: increment and re-normalize on carry-out
    assign sum      = {1'b0, s1_q.sig} + (SIG_W+1)'(s1_q.inc);
    assign carry    = sum[SIG_W];
    assign frac_adj = carry ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
    assign exp_adj  = s1_q.exp + EXPI_W'(carry);

    andtree #(.n(EXP_W)) u_exp_ones (
        .a   (exp_adj[EXP_W-1:0]),
        .y_c (exp_all_ones)
    );

    // Non-negative input only; then >=2048 shows in the guard bits, ==2047 in the AND tree
    assign ovf = ~s1_q.exp[EXPI_W-1]
               & (exp_adj[EXPI_W-1] | exp_adj[EXP_W] | exp_all_ones);
    assign unf = s1_q.exp[EXPI_W-1] | (s1_q.exp == '0);

    // Overflow saturates to infinity only when rounding away from the max finite value
    always_comb begin
        ovf_inf = 1'b0;
        case (s1_q.rm)
            RM_RNE:  ovf_inf = 1'b1;
            RM_RZ:   ovf_inf = 1'b0;
            RM_RU:   ovf_inf = ~s1_q.sign;
            RM_RD:   ovf_inf = s1_q.sign;
            default: ovf_inf = 1'b0;
        endcase
    end

    // Pack
    always_comb begin
        res_d   = {s1_q.sign, exp_adj[EXP_W-1:0], frac_adj};
        flags_d = '{ovf: 1'b0, unf: 1'b0, inx: s1_q.inx};
        if (unf) begin
            res_d   = {s1_q.sign, (RES_W-1)'(0)};
            flags_d = '{ovf: 1'b0, unf: 1'b1, inx: 1'b1};
        end else if (ovf) begin
            flags_d = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
            if (ovf_inf) begin
                res_d = {s1_q.sign, EXP_W'(EXP_MAX), {FRAC_W{1'b0}}};
            end else begin
                res_d = {s1_q.sign, EXP_W'(EXP_MAX - 1), {FRAC_W{1'b1}}};
            end
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_q    <= '0;
            res_o   <= '0;
            flags_o <= '0;
        end else begin
            if (in_ready) begin
                s1_v <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_q <= s1_d;
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    res_o   <= res_d;
                    flags_o <= flags_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_round_pack_pipe.sv
// Directed bench for round_pack_pipe with hand-computed binary64 results.
module tb_round_pack_pipe;
    import fpu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              sign_i;
    logic [EXPI_W-1:0] exp_i;
    logic [SIGI_W-1:0] sig_i;
    logic [1:0]        rm_i;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  res_o;
    logic [2:0]        flags_o;

    int total = 0;
    int bad   = 0;

    logic [SIGI_W-1:0] sig_one;      // 1.0, g=0 s=0
    logic [SIGI_W-1:0] sig_ones_g;   // frac all ones, g=1 s=0
    logic [SIGI_W-1:0] sig_tie_even; // frac 0, g=1 s=0
    logic [SIGI_W-1:0] sig_tie_odd;  // frac 1, g=1 s=0
    logic [SIGI_W-1:0] sig_sticky;   // frac 0, g=0 s=1

    round_pack_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_i    (sign_i),
        .exp_i     (exp_i),
        .sig_i     (sig_i),
        .rm_i      (rm_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_o     (res_o),
        .flags_o   (flags_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic s, input logic [EXPI_W-1:0] e,
                         input logic [SIGI_W-1:0] sg, input logic [1:0] rm);
        sign_i = s;
        exp_i  = e;
        sig_i  = sg;
        rm_i   = rm;
    endtask

    // One operand through an empty pipeline with out_ready=1; checks latency, result, flags
    task automatic op(input string tag, input logic s, input logic [EXPI_W-1:0] e,
                      input logic [SIGI_W-1:0] sg, input logic [1:0] rm,
                      input logic [63:0] eres, input logic [2:0] efl);
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        drive(s, e, sg, rm);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd2);
        check({tag, " res"}, res_o, eres);
        check({tag, " flags"}, 64'(flags_o), 64'(efl));
    endtask

    initial begin : stim
        logic seen;
        sig_one      = {1'b1, 52'h0, 2'b00};
        sig_ones_g   = {1'b1, {52{1'b1}}, 2'b10};
        sig_tie_even = {1'b1, 52'h0, 2'b10};
        sig_tie_odd  = {1'b1, 52'h1, 2'b10};
        sig_sticky   = {1'b1, 52'h0, 2'b01};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 2'b00);
        repeat (3) @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst res", res_o, 64'h0);
        check("rst flags", 64'(flags_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'd1);

        // Basic rounding
        op("one_rne",   1'b0, 13'(BIAS), sig_one,      2'b00, 64'h3FF0000000000000, 3'b000);
        op("carry_rne", 1'b0, 13'd1023,  sig_ones_g,   2'b00, 64'h4000000000000000, 3'b001);
        op("tie_even",  1'b0, 13'd1023,  sig_tie_even, 2'b00, 64'h3FF0000000000000, 3'b001);
        op("tie_odd",   1'b0, 13'd1023,  sig_tie_odd,  2'b00, 64'h3FF0000000000002, 3'b001);
        op("ru_pos",    1'b0, 13'd1023,  sig_sticky,   2'b10, 64'h3FF0000000000001, 3'b001);
        op("rd_pos",    1'b0, 13'd1023,  sig_sticky,   2'b11, 64'h3FF0000000000000, 3'b001);
        op("rd_neg",    1'b1, 13'd1023,  sig_sticky,   2'b11, 64'hBFF0000000000001, 3'b001);
        op("rz_ones",   1'b0, 13'd1023,  sig_ones_g,   2'b01, 64'h3FFFFFFFFFFFFFFF, 3'b001);

        // Overflow edges
        op("ovf_rne",   1'b0, 13'd2046,  sig_ones_g,   2'b00, 64'h7FF0000000000000, 3'b101);
        op("max_rz",    1'b0, 13'd2046,  sig_ones_g,   2'b01, 64'h7FEFFFFFFFFFFFFF, 3'b001);
        op("in2047_rz", 1'b0, 13'd2047,  sig_one,      2'b01, 64'h7FEFFFFFFFFFFFFF, 3'b101);
        op("in2047_ru", 1'b1, 13'd2047,  sig_one,      2'b10, 64'hFFEFFFFFFFFFFFFF, 3'b101);
        op("in2047_rd", 1'b1, 13'd2047,  sig_one,      2'b11, 64'hFFF0000000000000, 3'b101);
        op("big_rne",   1'b0, 13'd2304,  sig_one,      2'b00, 64'h7FF0000000000000, 3'b101);

        // Underflow edges
        op("zero_rd",   1'b1, 13'd0,     sig_one,      2'b11, 64'h8000000000000000, 3'b011);
        op("neg_exp",   1'b0, 13'h1FFF,  sig_one,      2'b00, 64'h0000000000000000, 3'b011);

        // Backpressure: three offered, two held, order preserved
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b0, 13'd1023, sig_one, 2'b00);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp in_ready s2_empty", 64'(in_ready), 64'd1);
        drive(1'b0, 13'd1023, sig_sticky, 2'b10);
        @(negedge clk);
        drive(1'b0, 13'd1023, sig_ones_g, 2'b00);
        check("bp in_ready full", 64'(in_ready), 64'd0);
        check("bp valid A", 64'(out_valid), 64'd1);
        check("bp res A", res_o, 64'h3FF0000000000000);
        repeat (2) @(negedge clk);
        check("bp hold in_ready", 64'(in_ready), 64'd0);
        check("bp hold valid", 64'(out_valid), 64'd1);
        check("bp hold res", res_o, 64'h3FF0000000000000);
        check("bp hold flags", 64'(flags_o), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp valid B", 64'(out_valid), 64'd1);
        check("bp res B", res_o, 64'h3FF0000000000001);
        check("bp flags B", 64'(flags_o), 64'd1);
        @(negedge clk);
        check("bp valid C", 64'(out_valid), 64'd1);
        check("bp res C", res_o, 64'h4000000000000000);
        @(negedge clk);
        check("bp drained", 64'(out_valid), 64'd0);

        // Reset with both stages full drops everything
        out_ready = 1'b0;
        drive(1'b0, 13'd1023, sig_one, 2'b00);
        in_valid = 1'b1;
        @(negedge clk);
        drive(1'b1, 13'd1023, sig_one, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid full in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid rst out_valid", 64'(out_valid), 64'd0);
        check("mid rst in_ready", 64'(in_ready), 64'd1);
        check("mid rst res", res_o, 64'h0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("mid rst no stale", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
